// File: rtl/baud_gen_frac_if.sv
// Control/status bundle for the fractional baud generator: run control,
// shadowed divisor writes, and the two tick outputs.
interface baud_gen_frac_if #(
   parameter int INT_W  = 16,
   parameter int FRAC_W = 4
) ();
   logic              en;
   logic              restart;
   logic              cfg_we;
   logic [INT_W-1:0]  cfg_int;
   logic [FRAC_W-1:0] cfg_frac;
   logic              cfg_osr8;
   logic              cfg_pending;
   logic              tick_os;
   logic              baud_en;

   modport master (
      output en, restart, cfg_we, cfg_int, cfg_frac, cfg_osr8,
      input  cfg_pending, tick_os, baud_en
   );

   modport slave (
      input  en, restart, cfg_we, cfg_int, cfg_frac, cfg_osr8,
      output cfg_pending, tick_os, baud_en
   );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: integer + fractional divisor via a phase
// accumulator, 8x/16x oversample ticks and bit ticks, shadowed divisor updates.
module baud_gen_frac #(
   parameter int               INT_W        = 16,
   parameter int               FRAC_W       = 4,
   parameter logic [INT_W-1:0]  DEFAULT_INT  = 27,
   parameter logic [FRAC_W-1:0] DEFAULT_FRAC = 2,
   parameter logic             DEFAULT_OSR8 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   baud_gen_frac_if.slave    bus
);

   logic [INT_W-1:0]  r_div_int, r_sh_int, r_cnt;
   logic [FRAC_W-1:0] r_div_frac, r_sh_frac, r_acc;
   logic              r_osr8, r_sh_osr8;
   logic [3:0]        r_os_cnt;
   logic              r_pending, r_tick, r_baud;

   logic [FRAC_W:0]   w_sum;
   logic              w_carry;
   logic [INT_W-1:0]  w_eff_int, w_term;
   logic              w_hit, w_os_wrap, w_apply;

   assign w_sum     = {1'b0, r_acc} + {1'b0, r_div_frac};
   assign w_carry   = w_sum[FRAC_W];
   assign w_eff_int = (r_div_int < INT_W'(2)) ? INT_W'(2) : r_div_int;
   assign w_term    = w_eff_int - INT_W'(1) + INT_W'(w_carry);
   // >= rather than == so a divisor shrunk while paused cannot strand cnt
   // above the new terminal count.
   assign w_hit     = bus.en && !bus.restart && (r_cnt >= w_term);
   assign w_os_wrap = (r_os_cnt == (r_osr8 ? 4'd7 : 4'd15));
   assign w_apply   = r_pending && (bus.restart || !bus.en || w_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_int  <= DEFAULT_INT;
         r_div_frac <= DEFAULT_FRAC;
         r_osr8     <= DEFAULT_OSR8;
         r_sh_int   <= DEFAULT_INT;
         r_sh_frac  <= DEFAULT_FRAC;
         r_sh_osr8  <= DEFAULT_OSR8;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_os_cnt   <= '0;
         r_pending  <= 1'b0;
         r_tick     <= 1'b0;
         r_baud     <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_baud <= 1'b0;
         if (bus.restart) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_os_cnt <= '0;
         end else if (bus.en) begin
            if (w_hit) begin
               r_cnt  <= '0;
               r_acc  <= w_sum[FRAC_W-1:0];
               r_tick <= 1'b1;
               if (w_os_wrap) begin
                  r_os_cnt <= '0;
                  r_baud   <= 1'b1;
               end else begin
                  r_os_cnt <= r_os_cnt + 4'd1;
               end
            end else begin
               r_cnt <= r_cnt + INT_W'(1);
            end
         end
         // Later assignments override: apply beats counting, a fresh write beats the clear.
         if (w_apply) begin
            r_div_int  <= r_sh_int;
            r_div_frac <= r_sh_frac;
            r_osr8     <= r_sh_osr8;
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_pending  <= 1'b0;
         end
         if (bus.cfg_we) begin
            r_sh_int  <= bus.cfg_int;
            r_sh_frac <= bus.cfg_frac;
            r_sh_osr8 <= bus.cfg_osr8;
            r_pending <= 1'b1;
         end
      end
   end

   assign bus.tick_os     = r_tick;
   assign bus.baud_en     = r_baud;
   assign bus.cfg_pending = r_pending;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick spacing, fractional dithering,
// oversample ratio, shadowed config, restart, enable hold and reset.
module tb_baud_gen_frac;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   stray = 0;

   baud_gen_frac_if #(.INT_W(16), .FRAC_W(4)) bus ();

   baud_gen_frac #(
      .INT_W(16), .FRAC_W(4), .DEFAULT_INT(16'd27), .DEFAULT_FRAC(4'd2), .DEFAULT_OSR8(1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Cycles (negedge samples) until the next tick_os; -1 if none within the bound.
   task automatic wait_tick(output int n, output bit b);
      n = -1;
      b = 1'b0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (bus.baud_en && !bus.tick_os) stray++;
         if (bus.tick_os) begin
            n = i;
            b = bus.baud_en;
            break;
         end
      end
   endtask

   task automatic cfg_write(input int vi, input int vf, input bit o8);
      bus.cfg_we   = 1'b1;
      bus.cfg_int  = 16'(vi);
      bus.cfg_frac = 4'(vf);
      bus.cfg_osr8 = o8;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
   endtask

   task automatic test_reset();
      bus.en = 1'b0; bus.restart = 1'b0; bus.cfg_we = 1'b0;
      bus.cfg_int = '0; bus.cfg_frac = '0; bus.cfg_osr8 = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.tick_os, bus.baud_en, bus.cfg_pending} !== 3'b000) begin
         errors++; $display("FAIL reset_outputs: got %b expected 000", {bus.tick_os, bus.baud_en, bus.cfg_pending});
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({bus.tick_os, bus.baud_en, bus.cfg_pending} !== 3'b000) begin
         errors++; $display("FAIL idle_outputs: got %b expected 000", {bus.tick_os, bus.baud_en, bus.cfg_pending});
      end
   endtask

   task automatic test_int_div();
      int n; bit b;
      bus.en = 1'b1;
      cfg_write(4, 0, 1'b0);
      checks++;
      if (bus.cfg_pending !== 1'b1) begin
         errors++; $display("FAIL int_pending_set: got %b expected 1", bus.cfg_pending);
      end
      do_restart();
      checks++;
      if (bus.cfg_pending !== 1'b0) begin
         errors++; $display("FAIL int_pending_clr: got %b expected 0", bus.cfg_pending);
      end
      for (int i = 1; i <= 32; i++) begin
         wait_tick(n, b);
         checks++;
         if (n !== 4) begin errors++; $display("FAIL int_gap[%0d]: got %0d expected 4", i, n); end
         checks++;
         if (b !== (i % 16 == 0)) begin errors++; $display("FAIL int_baud[%0d]: got %b expected %b", i, b, (i % 16 == 0)); end
      end
   endtask

   task automatic test_frac_div();
      int n; bit b; int total;
      cfg_write(4, 8, 1'b0);
      do_restart();
      total = 0;
      for (int i = 1; i <= 16; i++) begin
         wait_tick(n, b);
         total += n;
         checks++;
         if (n !== ((i % 2 == 1) ? 4 : 5)) begin
            errors++; $display("FAIL frac_gap[%0d]: got %0d expected %0d", i, n, (i % 2 == 1) ? 4 : 5);
         end
      end
      checks++;
      if (total !== 72) begin errors++; $display("FAIL frac_span16: got %0d expected 72", total); end
   endtask

   task automatic test_osr8();
      int n; bit b; int since;
      cfg_write(3, 0, 1'b1);
      do_restart();
      since = 0;
      for (int i = 1; i <= 16; i++) begin
         wait_tick(n, b);
         since += n;
         checks++;
         if (n !== 3) begin errors++; $display("FAIL osr8_gap[%0d]: got %0d expected 3", i, n); end
         checks++;
         if (b !== (i % 8 == 0)) begin errors++; $display("FAIL osr8_baud[%0d]: got %b expected %b", i, b, (i % 8 == 0)); end
         if (b) begin
            checks++;
            if (since !== 24) begin errors++; $display("FAIL osr8_baud_period: got %0d expected 24", since); end
            since = 0;
         end
      end
   endtask

   task automatic test_shadow_apply();
      int n; bit b;
      cfg_write(6, 0, 1'b0);
      do_restart();
      wait_tick(n, b);
      checks++;
      if (n !== 6) begin errors++; $display("FAIL shadow_first: got %0d expected 6", n); end
      repeat (2) @(negedge clk);
      cfg_write(10, 0, 1'b0);
      checks++;
      if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL shadow_pending: got %b expected 1", bus.cfg_pending); end
      wait_tick(n, b);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL shadow_old_spacing: got %0d expected 3", n); end
      checks++;
      if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL shadow_pending_fall: got %b expected 0", bus.cfg_pending); end
      for (int i = 1; i <= 16; i++) begin
         wait_tick(n, b);
         checks++;
         if (n !== 10) begin errors++; $display("FAIL shadow_new_gap[%0d]: got %0d expected 10", i, n); end
         checks++;
         if (b !== (i == 16)) begin errors++; $display("FAIL shadow_baud[%0d]: got %b expected %b", i, b, (i == 16)); end
      end
   endtask

   task automatic test_last_wins();
      int n; bit b;
      bus.cfg_we = 1'b1; bus.cfg_int = 16'd7; bus.cfg_frac = 4'd0; bus.cfg_osr8 = 1'b0;
      @(negedge clk);
      bus.cfg_int = 16'd8;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      checks++;
      if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL lastwin_pending: got %b expected 1", bus.cfg_pending); end
      do_restart();
      for (int i = 1; i <= 2; i++) begin
         wait_tick(n, b);
         checks++;
         if (n !== 8) begin errors++; $display("FAIL lastwin_gap[%0d]: got %0d expected 8", i, n); end
      end
   endtask

   task automatic test_restart();
      int n; bit b;
      cfg_write(6, 8, 1'b0);
      do_restart();
      wait_tick(n, b);
      checks++;
      if (n !== 6) begin errors++; $display("FAIL restart_pre: got %0d expected 6", n); end
      repeat (2) @(negedge clk);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      checks++;
      if (bus.tick_os !== 1'b0) begin errors++; $display("FAIL restart_no_tick: got %b expected 0", bus.tick_os); end
      // acc cleared by restart, so the dithered sequence starts again at 6
      wait_tick(n, b);
      checks++;
      if (n !== 6) begin errors++; $display("FAIL restart_first: got %0d expected 6", n); end
      wait_tick(n, b);
      checks++;
      if (n !== 7) begin errors++; $display("FAIL restart_second: got %0d expected 7", n); end
   endtask

   task automatic test_enable();
      int n; bit b; int seen;
      cfg_write(6, 0, 1'b0);
      do_restart();
      wait_tick(n, b);
      checks++;
      if (n !== 6) begin errors++; $display("FAIL en_pre: got %0d expected 6", n); end
      repeat (2) @(negedge clk);
      bus.en = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.tick_os || bus.baud_en) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL en_low_ticks: got %0d expected 0", seen); end
      cfg_write(5, 0, 1'b0);
      checks++;
      if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL en_low_pending: got %b expected 1", bus.cfg_pending); end
      @(negedge clk);
      checks++;
      if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL en_low_apply: got %b expected 0", bus.cfg_pending); end
      bus.en = 1'b1;
      wait_tick(n, b);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL en_resume: got %0d expected 3", n); end
      wait_tick(n, b);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL en_after: got %0d expected 5", n); end
   endtask

   task automatic test_async_reset();
      int n; bit b;
      repeat (4) @(negedge clk);
      cfg_write(9, 0, 1'b0);
      checks++;
      if ({bus.tick_os, bus.cfg_pending} !== 2'b11) begin
         errors++; $display("FAIL rst_pre_state: got %b expected 11", {bus.tick_os, bus.cfg_pending});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.tick_os, bus.baud_en, bus.cfg_pending} !== 3'b000) begin
         errors++; $display("FAIL rst_async: got %b expected 000", {bus.tick_os, bus.baud_en, bus.cfg_pending});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wait_tick(n, b);
         checks++;
         if (n !== ((i == 8) ? 28 : 27)) begin
            errors++; $display("FAIL rst_default_gap[%0d]: got %0d expected %0d", i, n, (i == 8) ? 28 : 27);
         end
      end
   endtask

   task automatic test_no_stray();
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL stray_baud: got %0d expected 0", stray); end
   endtask

   initial begin
      test_reset();
      test_int_div();
      test_frac_div();
      test_osr8();
      test_shadow_apply();
      test_last_wins();
      test_restart();
      test_enable();
      test_async_reset();
      test_no_stray();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Programmable fractional baud-rate generator for the APB UART. It replaces the fixed-parameter generator with a run-time divisor: integer and fractional parts, plus a selectable 8x/16x oversampling ratio. It produces a one-cycle oversample tick for the RX sampler and a one-cycle bit tick for the TX shifter. A restart input lets RX re-align the phase on start-bit detection; divisor changes are shadowed and applied glitch-free on a tick boundary.

## Interface
- INT_W, 16, width of the integer divisor (clocks per oversample tick)
- FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W clock)
- DEFAULT_INT, 27, reset value of the active integer divisor (50 MHz / (115200*16) = 27.13)
- DEFAULT_FRAC, 2, reset value of the active fractional divisor
- DEFAULT_OSR8, 0, reset value of the oversample select (0 = 16x, 1 = 8x)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  count enable
- restart  input  1  synchronous phase restart; priority over en
- cfg_we  input  1  one-cycle write strobe for cfg_int/cfg_frac/cfg_osr8
- cfg_int  input  INT_W  integer divisor; values 0 and 1 are treated as 2
- cfg_frac  input  FRAC_W  fractional divisor
- cfg_osr8  input  1  oversample select (1 = 8x, 0 = 16x)
- cfg_pending  output  1  shadow config written but not yet applied
- tick_os  output  1  registered one-cycle oversample tick
- baud_en  output  1  registered one-cycle bit tick; always coincident with a tick_os

## Operation
- State:
  - active divisor: div_int, div_frac, osr8
  - shadow copy of the divisor
  - cnt (INT_W bits)
  - phase accumulator acc (FRAC_W bits)
  - os_cnt (4 bits)
- Reset:
  - Active registers = DEFAULT_*; shadow = DEFAULT_*.
  - cnt = acc = os_cnt = 0.
  - tick_os = baud_en = cfg_pending = 0.
- Period rule:
  - Define sum = acc + div_frac (FRAC_W+1 bits) and carry = sum[FRAC_W].
  - Terminal count T = eff_int - 1 + carry, where eff_int = max(div_int, 2).
  - Each en cycle: if cnt != T then cnt++; else cnt <= 0, acc <= sum[FRAC_W-1:0], tick_os <= 1.
  - Result: over any 2^FRAC_W consecutive ticks, exactly div_frac periods last eff_int+1 clocks; the rest last eff_int clocks.
- Oversample counter:
  - os_cnt advances on every tick; OSR = 8 if osr8 else 16.
  - On a tick with os_cnt == OSR-1: os_cnt <= 0, baud_en <= 1. Otherwise os_cnt++.
- Outputs are 0 on every cycle not explicitly pulsed.
- en = 0: cnt, acc and os_cnt hold; no ticks are produced.
- restart = 1:
  - cnt, acc, os_cnt <= 0; tick_os and baud_en <= 0.
  - Any pending shadow is applied on the same edge.
- Configuration:
  - cfg_we loads the shadow and sets cfg_pending; the last write wins.
  - Apply point is the first edge that produces a tick, or any edge with en = 0, or restart.
  - On apply: active <= shadow; acc <= 0; os_cnt <= 0; cfg_pending <= 0.
- Simultaneous events:
  - cfg_we on the apply edge: the old shadow is applied, the new value is captured, and cfg_pending stays 1.
  - restart together with en: restart wins.

## Timing
- tick_os latency: with en held high from edge 1 after cnt = 0, tick_os is high after edges P, P+P', and so on (P = per-period length). It is registered with no combinational path from inputs.
- baud_en rises on the same edge as the OSR-th tick_os.
- First tick after restart (restart high at edge k, en high afterwards): edge k + eff_int, plus 1 if the first carry is set. With acc = 0, that carry is set only if div_frac = 2^FRAC_W... impossible, so it is always edge k + eff_int.
- cfg_pending falls on the apply edge; the new period governs counting from the next edge.
- Reset asserted mid-operation: all outputs 0 immediately (asynchronous); pending config is discarded.

## Test plan
- Reset, then en = 1 with cfg int = 4, frac = 0, osr8 = 0 applied via restart -> tick_os every 4 clocks; baud_en every 64 clocks, coincident with every 16th tick.
- int = 4, frac = 8 (FRAC_W = 4) -> period lengths 4, 5, 4, 5…; 16 ticks span exactly 72 clocks.
- osr8 = 1, int = 3 -> baud_en every 24 clocks, on every 8th tick_os.
- cfg_we of int = 10 at mid-period with int = 6 -> cfg_pending = 1 until the next tick edge; that tick is at the old 6-clock spacing, subsequent ticks at 10; os_cnt restarts, so baud_en comes 16 ticks after apply.
- restart at clock 3 of a 6-clock period -> no tick at the old position; next tick exactly 6 clocks after the restart edge; acc = 0.
- en low for 20 clocks mid-period, then high -> no ticks while low; counting resumes from the held cnt. rst_n pulsed mid-period -> outputs 0 at once; after release, divisor = DEFAULT_INT/DEFAULT_FRAC.
